// File: rtl/frame_sink_buf.sv
// frame_sink_buf: captures one full video frame into on-chip memory on request,
// then drains it as a valid/ready stream with an end-of-frame marker.
// A capture starts only on a frame start (rising vvalid), so arming mid-frame
// waits for the next complete frame.
module frame_sink_buf #(
  parameter  int CH    = 3,
  parameter  int DW    = 8,
  parameter  int HRES  = 1920,
  parameter  int VRES  = 1080,
  localparam int DEPTH = HRES * VRES,
  localparam int AW    = $clog2(DEPTH + 1),
  localparam int WW    = CH * DW
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          hvalid,
  input  logic          vvalid,
  input  logic [WW-1:0] din,
  input  logic          arm,
  input  logic          continuous,
  output logic [WW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          ovf,
  output logic [AW-1:0] pix_cnt,
  output logic [15:0]   frame_cnt
);

  // Memory address width; pix_cnt needs one extra code to represent "full".
  localparam int              MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   DEPTH_W = AW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPT,
    DRAIN
  } state_t;

  state_t        state;
  logic          vvalid_q;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] mem [DEPTH];

  logic pix_in;
  logic sof;
  logic eof;
  logic cap_we;
  logic beat;
  logic load;

  assign pix_in = hvalid && vvalid;
  assign sof    = vvalid && !vvalid_q;
  assign eof    = !vvalid && vvalid_q;
  assign cap_we = (state == CAPT) && pix_in && (pix_cnt != DEPTH_W);
  assign beat   = m_valid && m_ready;
  // The output register may take a new word when empty or being accepted.
  assign load   = !m_valid || m_ready;
  assign busy   = (state != IDLE);

  // Frame store write port; capture address is simply the running pixel count.
  // NOTE: the storage array has no reset -- clearing a frame-sized RAM is
  // neither possible in block RAM nor needed, since pix_cnt bounds every read.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem[pix_cnt[MW-1:0]] <= din;
    end
  end

  // Control FSM, capture counting and the registered drain output stage
  // (m_data doubles as the synchronous read register of the frame store).
  // NOTE: all state here is assigned with <= so every register samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      vvalid_q  <= 1'b0;
      rd_addr   <= '0;
      pix_cnt   <= '0;
      ovf       <= 1'b0;
      frame_cnt <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      vvalid_q <= vvalid;
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= WAIT_SOF;
            pix_cnt <= '0;
            ovf     <= 1'b0;
          end
        end

        WAIT_SOF: begin
          if (sof) begin
            state <= CAPT;
          end
        end

        CAPT: begin
          if (pix_in) begin
            if (pix_cnt != DEPTH_W) begin
              pix_cnt <= pix_cnt + AW'(1);
            end else begin
              ovf <= 1'b1;
            end
          end
          if (eof) begin
            if (pix_cnt != '0) begin
              state   <= DRAIN;
              rd_addr <= '0;
            end else if (continuous) begin
              state <= WAIT_SOF;
              ovf   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        DRAIN: begin
          if (beat && m_last) begin
            frame_cnt <= frame_cnt + 16'd1;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            if (continuous) begin
              state   <= WAIT_SOF;
              pix_cnt <= '0;
              ovf     <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (load) begin
            if (rd_addr != pix_cnt) begin
              m_data  <= mem[rd_addr[MW-1:0]];
              m_valid <= 1'b1;
              m_last  <= (rd_addr == pix_cnt - AW'(1));
              rd_addr <= rd_addr + AW'(1);
            end else begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_sink_buf.md
FRAME_SINK_BUF -- requirements
Module: frame_sink_buf

Interface
REQ-001 Parameter CH, default 3, number of parallel pixel channels packed per word.
REQ-002 Parameter DW, default 8, bits per channel.
REQ-003 Parameter HRES, default 1920, active pixels per line; VRES, default 1080, active lines per frame.
REQ-004 Derived: DEPTH=HRES*VRES words; AW=clog2(DEPTH+1); WW=CH*DW.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_b  in  1  asynchronous, active-low reset.
REQ-007 hvalid  in  1  line-active qualifier.
REQ-008 vvalid  in  1  frame-active qualifier.
REQ-009 din  in  WW  pixel word, channel 0 in LSBs.
REQ-010 arm  in  1  single-cycle request to capture the next full frame.
REQ-011 continuous  in  1  re-arm automatically after each drain.
REQ-012 m_data  out  WW  drained pixel word.
REQ-013 m_valid  out  1  m_data valid.
REQ-014 m_ready  in  1  downstream accept.
REQ-015 m_last  out  1  marks final word of a drained frame.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 ovf  out  1  sticky: frame exceeded DEPTH pixels.
REQ-018 pix_cnt  out  AW  pixels captured in current/last frame.
REQ-019 frame_cnt  out  16  completed drains, wraps 0xFFFF->0.

Function
REQ-020 States: IDLE, WAIT_SOF, CAPT, DRAIN.
REQ-021 IDLE -> WAIT_SOF on arm; arm outside IDLE ignored.
REQ-022 WAIT_SOF -> CAPT on vvalid rising edge (vvalid=1, registered vvalid=0); mid-frame arm therefore skips the partial frame.
REQ-023 Entry to WAIT_SOF clears pix_cnt and ovf.
REQ-024 CAPT: each cycle with hvalid&&vvalid and pix_cnt<DEPTH writes din to memory at address pix_cnt, pix_cnt+1.
REQ-025 CAPT: hvalid&&vvalid with pix_cnt==DEPTH drops the word and sets ovf; ovf holds until next WAIT_SOF entry or reset.
REQ-026 CAPT -> DRAIN on vvalid falling edge if pix_cnt>0; if pix_cnt==0, -> WAIT_SOF when continuous=1, else IDLE.
REQ-027 DRAIN ignores hvalid, vvalid, din, arm.
REQ-028 DRAIN emits addresses 0..pix_cnt-1 in order, one word per m_valid&&m_ready handshake.
REQ-029 Memory is synchronous-read, 1-cycle latency; first m_valid no later than 2 cycles after DRAIN entry.
REQ-030 While m_valid=1 and m_ready=0, m_data and m_last hold stable; no word lost or duplicated.
REQ-031 Sustained throughput with m_ready=1 is one word per cycle after first word.
REQ-032 m_last=1 only with the word at address pix_cnt-1.
REQ-033 On handshake of m_last: frame_cnt+1; -> WAIT_SOF if continuous=1 sampled that cycle, else IDLE; m_valid=0 next cycle.
REQ-034 Deasserting continuous during CAPT/DRAIN completes current frame then returns to IDLE.
REQ-035 pix_cnt is not cleared on drain completion; it reflects the last frame until next WAIT_SOF.

Reset
REQ-036 rst_b=0 asynchronously forces state IDLE, m_valid=0, m_last=0, busy=0, ovf=0, pix_cnt=0, frame_cnt=0, m_data=0.
REQ-037 Memory contents are not reset; reset mid-CAPT or mid-DRAIN abandons the frame with no further outputs.
REQ-038 After rst_b release, no capture occurs until arm.

Verification (CH=3, DW=8, HRES=4, VRES=2, DEPTH=8)
REQ-039 arm, then 8-pixel frame din=0x000001..0x000008, m_ready=1 -> 8 beats in order, m_last on 0x000008, frame_cnt=1, busy=0 after.
REQ-040 Same frame, m_ready toggling 1,0,0,1,... -> identical 8-word sequence, m_data stable during stalls.
REQ-041 10-pixel frame -> ovf=1, pix_cnt=8, beats 1..8 only, m_last on 8th.
REQ-042 5-pixel frame -> 5 beats, m_last on 5th, pix_cnt=5.
REQ-043 arm while vvalid=1 mid-frame -> that frame not captured; next frame captured fully; continuous=1 -> two consecutive frames drained, frame_cnt=2.
REQ-044 rst_b low during DRAIN after 3 beats -> m_valid=0 same cycle, busy=0, frame_cnt=0; fresh arm captures normally.
